// File: rtl/pulp_power_gating_ctrl.sv
// Per-domain power-gating sequencer: orders isolation, retention, switch control and
// domain reset for each gated domain and supervises the switch-chain acknowledge.
module pulp_power_gating_ctrl #(
  parameter int unsigned NB_DOMAINS  = 1,
  parameter int unsigned ISO_CYCLES  = 4,
  parameter int unsigned RET_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NB_DOMAINS-1:0] pwr_off_req_i,
  output logic [NB_DOMAINS-1:0] sleep_o,
  input  logic [NB_DOMAINS-1:0] sleepout_i,
  output logic [NB_DOMAINS-1:0] iso_o,
  output logic [NB_DOMAINS-1:0] ret_o,
  output logic [NB_DOMAINS-1:0] rst_dom_no,
  output logic [NB_DOMAINS-1:0] off_o,
  output logic [NB_DOMAINS-1:0] busy_o,
  output logic [NB_DOMAINS-1:0] err_o,
  input  logic [NB_DOMAINS-1:0] err_clr_i
);

  localparam int unsigned MAX_IR  = (ISO_CYCLES > RET_CYCLES) ? ISO_CYCLES : RET_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_IR > ACK_TIMEOUT) ? MAX_IR : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_ON, ST_ISO, ST_SAVE, ST_PWROFF, ST_OFF, ST_PWRON, ST_RESTORE, ST_UNISO
  } state_e;

  for (genvar d = 0; d < NB_DOMAINS; d++) begin : g_dom
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sleep_q, sleep_d;
    logic             iso_q, iso_d;
    logic             ret_q, ret_d;
    logic             rst_dom_n_q, rst_dom_n_d;
    logic             off_q, off_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             timeout;

    // Next state, dwell counter and sticky error
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      timeout = 1'b0;
      case (state_q)
        ST_ON: begin
          if (pwr_off_req_i[d]) state_d = ST_ISO;
        end
        ST_ISO: begin
          if (cnt_q == ISO_LAST) begin
            state_d = ST_SAVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SAVE: begin
          if (cnt_q == RET_LAST) begin
            state_d = ST_PWROFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PWROFF: begin
          if (sleepout_i[d] || (cnt_q == ACK_LAST)) begin
            timeout = !sleepout_i[d];
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (!pwr_off_req_i[d]) state_d = ST_PWRON;
        end
        ST_PWRON: begin
          if (!sleepout_i[d] || (cnt_q == ACK_LAST)) begin
            timeout = sleepout_i[d];
            state_d = ST_RESTORE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RESTORE: begin
          if (cnt_q == RET_LAST) begin
            state_d = ST_UNISO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_UNISO: begin
          if (cnt_q == ISO_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      endcase

      if (err_clr_i[d]) err_d = 1'b0;
      if (timeout)      err_d = 1'b1;
    end

    // Output decode of the upcoming state so the registered outputs track the state
    always_comb begin
      sleep_d     = 1'b0;
      iso_d       = 1'b0;
      ret_d       = 1'b0;
      rst_dom_n_d = 1'b1;
      off_d       = 1'b0;
      busy_d      = 1'b1;
      case (state_d)
        ST_ON: busy_d = 1'b0;
        ST_ISO: iso_d = 1'b1;
        ST_SAVE: begin
          iso_d = 1'b1;
          ret_d = 1'b1;
        end
        ST_PWROFF: begin
          sleep_d     = 1'b1;
          iso_d       = 1'b1;
          ret_d       = 1'b1;
          rst_dom_n_d = 1'b0;
        end
        ST_OFF: begin
          sleep_d     = 1'b1;
          iso_d       = 1'b1;
          ret_d       = 1'b1;
          rst_dom_n_d = 1'b0;
          off_d       = 1'b1;
          busy_d      = 1'b0;
        end
        ST_PWRON: begin
          iso_d       = 1'b1;
          ret_d       = 1'b1;
          rst_dom_n_d = 1'b0;
        end
        ST_RESTORE: begin
          iso_d = 1'b1;
          ret_d = 1'b1;
        end
        ST_UNISO: iso_d = 1'b1;
        default: busy_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q     <= ST_ON;
        cnt_q       <= '0;
        sleep_q     <= 1'b0;
        iso_q       <= 1'b0;
        ret_q       <= 1'b0;
        rst_dom_n_q <= 1'b1;
        off_q       <= 1'b0;
        busy_q      <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        sleep_q     <= sleep_d;
        iso_q       <= iso_d;
        ret_q       <= ret_d;
        rst_dom_n_q <= rst_dom_n_d;
        off_q       <= off_d;
        busy_q      <= busy_d;
        err_q       <= err_d;
      end
    end

    assign sleep_o[d]    = sleep_q;
    assign iso_o[d]      = iso_q;
    assign ret_o[d]      = ret_q;
    assign rst_dom_no[d] = rst_dom_n_q;
    assign off_o[d]      = off_q;
    assign busy_o[d]     = busy_q;
    assign err_o[d]      = err_q;
  end

endmodule

// File: tb/tb_pulp_power_gating_ctrl.sv
// Scoreboard bench for pulp_power_gating_ctrl: expected per-cycle outputs are queued
// from the documented sequence timing and compared as the DUT advances.
module tb_pulp_power_gating_ctrl;

  localparam int ND    = 3;
  localparam int ISO_C = 4;
  localparam int RET_C = 4;
  localparam int ACK_T = 16;
  localparam int ECHO  = 3;

  localparam int S_ON = 0, S_ISO = 1, S_SAVE = 2, S_PWROFF = 3;
  localparam int S_OFF = 4, S_PWRON = 5, S_RESTORE = 6, S_UNISO = 7;

  typedef struct packed {
    logic sleep;
    logic iso;
    logic ret;
    logic rst_n;
    logic off;
    logic busy;
    logic err;
  } exp_t;

  typedef struct {
    int   cyc;
    int   dom;
    exp_t e;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [ND-1:0] req, sleep, sleepout, iso, ret, rst_dom_n, off, busy, err, err_clr;
  logic [ND-1:0] stuck;
  logic [ND-1:0] st1 = '0, st2 = '0, st3 = '0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  sb_t           sbq[$];

  pulp_power_gating_ctrl #(
    .NB_DOMAINS (ND),
    .ISO_CYCLES (ISO_C),
    .RET_CYCLES (RET_C),
    .ACK_TIMEOUT(ACK_T)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pwr_off_req_i(req),
    .sleep_o      (sleep),
    .sleepout_i   (sleepout),
    .iso_o        (iso),
    .ret_o        (ret),
    .rst_dom_no   (rst_dom_n),
    .off_o        (off),
    .busy_o       (busy),
    .err_o        (err),
    .err_clr_i    (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Switch-chain model: sleepout follows sleep after ECHO cycles unless stuck low
  always @(posedge clk) begin
    st1 <= sleep;
    st2 <= st1;
    st3 <= st2;
  end
  assign sleepout = st3 & ~stuck;

  function automatic exp_t exp_of(input int st, input logic e_err);
    exp_t e;
    case (st)
      S_ON:      {e.sleep, e.iso, e.ret, e.rst_n, e.off, e.busy} = 6'b000100;
      S_ISO:     {e.sleep, e.iso, e.ret, e.rst_n, e.off, e.busy} = 6'b010101;
      S_SAVE:    {e.sleep, e.iso, e.ret, e.rst_n, e.off, e.busy} = 6'b011101;
      S_PWROFF:  {e.sleep, e.iso, e.ret, e.rst_n, e.off, e.busy} = 6'b111001;
      S_OFF:     {e.sleep, e.iso, e.ret, e.rst_n, e.off, e.busy} = 6'b111010;
      S_PWRON:   {e.sleep, e.iso, e.ret, e.rst_n, e.off, e.busy} = 6'b011001;
      S_RESTORE: {e.sleep, e.iso, e.ret, e.rst_n, e.off, e.busy} = 6'b011101;
      default:   {e.sleep, e.iso, e.ret, e.rst_n, e.off, e.busy} = 6'b010101;
    endcase
    e.err = e_err;
    return e;
  endfunction

  function automatic exp_t actual(input int d);
    exp_t a;
    a.sleep = sleep[d];
    a.iso   = iso[d];
    a.ret   = ret[d];
    a.rst_n = rst_dom_n[d];
    a.off   = off[d];
    a.busy  = busy[d];
    a.err   = err[d];
    return a;
  endfunction

  task automatic expect_st(input int d, input int from, input int n, input int st,
                           input logic e_err);
    sb_t t;
    for (int i = 0; i < n; i++) begin
      t.cyc = from + i;
      t.dom = d;
      t.e   = exp_of(st, e_err);
      sbq.push_back(t);
    end
  endtask

  // Power-down timeline for a request seen by the FSM at cycle s, echoing chain
  task automatic push_off(input int d, input int s);
    expect_st(d, s + 1, ISO_C, S_ISO, 1'b0);
    expect_st(d, s + 1 + ISO_C, RET_C, S_SAVE, 1'b0);
    expect_st(d, s + 1 + ISO_C + RET_C, ECHO + 1, S_PWROFF, 1'b0);
  endtask

  task automatic push_on(input int d, input int s, input logic e_err);
    expect_st(d, s + 1, ECHO + 1, S_PWRON, e_err);
    expect_st(d, s + 2 + ECHO, RET_C, S_RESTORE, e_err);
    expect_st(d, s + 2 + ECHO + RET_C, ISO_C, S_UNISO, e_err);
  endtask

  task automatic test_reset();
    int c0;
    rst_n = 1'b1; req = '0; err_clr = '0; stuck = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (actual(d) !== exp_of(S_ON, 1'b0)) begin
        errors++;
        $display("FAIL reset_hold dom%0d: got %b want %b", d, actual(d), exp_of(S_ON, 1'b0));
      end
    end
    rst_n = 1'b1;
    c0 = cyc;
    for (int d = 0; d < ND; d++) expect_st(d, c0 + 1, 4, S_ON, 1'b0);
    repeat (4) begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          checks++;
          if (actual(sbq[i].dom) !== sbq[i].e) begin
            errors++;
            $display("FAIL reset_release dom%0d cyc%0d: got %b want %b",
                     sbq[i].dom, cyc, actual(sbq[i].dom), sbq[i].e);
          end
          sbq.delete(i);
        end
      end
    end
  endtask

  task automatic test_off_on();
    int c0;
    c0 = cyc;
    req[0] = 1'b1;
    push_off(0, c0);
    expect_st(0, c0 + 13, 6, S_OFF, 1'b0);
    push_on(0, c0 + 18, 1'b0);
    expect_st(0, c0 + 31, 3, S_ON, 1'b0);
    for (int d = 1; d < ND; d++) expect_st(d, c0 + 1, 33, S_ON, 1'b0);
    repeat (33) begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          checks++;
          if (actual(sbq[i].dom) !== sbq[i].e) begin
            errors++;
            $display("FAIL off_on dom%0d cyc+%0d: got %b want %b",
                     sbq[i].dom, cyc - c0, actual(sbq[i].dom), sbq[i].e);
          end
          sbq.delete(i);
        end
      end
      if (cyc == c0 + 18) req[0] = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int c0;
    c0 = cyc;
    stuck[1] = 1'b1;
    req[1]   = 1'b1;
    expect_st(1, c0 + 1, ISO_C, S_ISO, 1'b0);
    expect_st(1, c0 + 5, RET_C, S_SAVE, 1'b0);
    expect_st(1, c0 + 9, ACK_T, S_PWROFF, 1'b0);
    expect_st(1, c0 + 25, 4, S_OFF, 1'b1);
    expect_st(1, c0 + 29, 3, S_OFF, 1'b0);
    push_on(1, c0 + 31, 1'b0);
    expect_st(1, c0 + 44, 2, S_ON, 1'b0);
    expect_st(0, c0 + 1, 45, S_ON, 1'b0);
    expect_st(2, c0 + 1, 45, S_ON, 1'b0);
    repeat (45) begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          checks++;
          if (actual(sbq[i].dom) !== sbq[i].e) begin
            errors++;
            $display("FAIL timeout dom%0d cyc+%0d: got %b want %b",
                     sbq[i].dom, cyc - c0, actual(sbq[i].dom), sbq[i].e);
          end
          sbq.delete(i);
        end
      end
      if (cyc == c0 + 28) err_clr[1] = 1'b1;
      if (cyc == c0 + 29) begin
        err_clr[1] = 1'b0;
        stuck[1]   = 1'b0;
      end
      if (cyc == c0 + 31) req[1] = 1'b0;
    end
  endtask

  task automatic test_glitch();
    int c0;
    c0 = cyc;
    req[2] = 1'b1;
    push_off(2, c0);
    expect_st(2, c0 + 13, 1, S_OFF, 1'b0);
    push_on(2, c0 + 13, 1'b0);
    expect_st(2, c0 + 26, 2, S_ON, 1'b0);
    expect_st(0, c0 + 1, 27, S_ON, 1'b0);
    expect_st(1, c0 + 1, 27, S_ON, 1'b0);
    repeat (27) begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          checks++;
          if (actual(sbq[i].dom) !== sbq[i].e) begin
            errors++;
            $display("FAIL glitch dom%0d cyc+%0d: got %b want %b",
                     sbq[i].dom, cyc - c0, actual(sbq[i].dom), sbq[i].e);
          end
          sbq.delete(i);
        end
      end
      for (int d = 0; d < ND; d++) begin
        checks++;
        if ((ret[d] | sleep[d] | ~rst_dom_n[d]) & ~iso[d]) begin
          errors++;
          $display("FAIL invariant dom%0d cyc+%0d: iso=%b ret=%b sleep=%b rst_n=%b",
                   d, cyc - c0, iso[d], ret[d], sleep[d], rst_dom_n[d]);
        end
      end
      if (cyc == c0 + 2) req[2] = 1'b0;
      if (cyc == c0 + 3) req[2] = 1'b1;
      if (cyc == c0 + 6) req[2] = 1'b0;
    end
  endtask

  task automatic test_multi();
    int c0;
    c0 = cyc;
    req[0] = 1'b1;
    req[2] = 1'b1;
    push_off(0, c0);
    push_off(2, c0);
    push_off(1, c0 + 2);
    expect_st(0, c0 + 13, 8, S_OFF, 1'b0);
    expect_st(2, c0 + 13, 8, S_OFF, 1'b0);
    expect_st(1, c0 + 15, 6, S_OFF, 1'b0);
    for (int d = 0; d < ND; d++) begin
      push_on(d, c0 + 20, 1'b0);
      expect_st(d, c0 + 33, 2, S_ON, 1'b0);
    end
    repeat (34) begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          checks++;
          if (actual(sbq[i].dom) !== sbq[i].e) begin
            errors++;
            $display("FAIL multi dom%0d cyc+%0d: got %b want %b",
                     sbq[i].dom, cyc - c0, actual(sbq[i].dom), sbq[i].e);
          end
          sbq.delete(i);
        end
      end
      for (int d = 0; d < ND; d++) begin
        checks++;
        if ((ret[d] | sleep[d] | ~rst_dom_n[d]) & ~iso[d]) begin
          errors++;
          $display("FAIL invariant dom%0d cyc+%0d: iso=%b ret=%b sleep=%b rst_n=%b",
                   d, cyc - c0, iso[d], ret[d], sleep[d], rst_dom_n[d]);
        end
      end
      if (cyc == c0 + 2) req[1] = 1'b1;
      if (cyc == c0 + 20) req = '0;
    end
  endtask

  task automatic test_reset_pwroff();
    int c0;
    int c1;
    c0 = cyc;
    stuck  = 3'b011;
    req[0] = 1'b1;
    expect_st(0, c0 + 1, ISO_C, S_ISO, 1'b0);
    expect_st(0, c0 + 5, RET_C, S_SAVE, 1'b0);
    expect_st(0, c0 + 9, ACK_T, S_PWROFF, 1'b0);
    expect_st(0, c0 + 25, 1, S_OFF, 1'b1);
    expect_st(1, c0 + 13, ISO_C, S_ISO, 1'b0);
    expect_st(1, c0 + 17, RET_C, S_SAVE, 1'b0);
    expect_st(1, c0 + 21, 5, S_PWROFF, 1'b0);
    expect_st(2, c0 + 1, 25, S_ON, 1'b0);
    repeat (25) begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          checks++;
          if (actual(sbq[i].dom) !== sbq[i].e) begin
            errors++;
            $display("FAIL rst_pwroff dom%0d cyc+%0d: got %b want %b",
                     sbq[i].dom, cyc - c0, actual(sbq[i].dom), sbq[i].e);
          end
          sbq.delete(i);
        end
      end
      if (cyc == c0 + 12) req[1] = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (actual(d) !== exp_of(S_ON, 1'b0)) begin
        errors++;
        $display("FAIL rst_async dom%0d: got %b want %b", d, actual(d), exp_of(S_ON, 1'b0));
      end
    end
    req   = '0;
    stuck = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c1 = cyc;
    for (int d = 0; d < ND; d++) expect_st(d, c1 + 1, 5, S_ON, 1'b0);
    repeat (5) begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          checks++;
          if (actual(sbq[i].dom) !== sbq[i].e) begin
            errors++;
            $display("FAIL rst_release dom%0d cyc+%0d: got %b want %b",
                     sbq[i].dom, cyc - c1, actual(sbq[i].dom), sbq[i].e);
          end
          sbq.delete(i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_off_on();
    test_timeout();
    test_glitch();
    test_multi();
    test_reset_pwroff();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
